// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: reset hold, sequential advance,
// branch/trap redirect with a one-entry pending buffer for events seen under stall.
module pc_gen #(
    parameter int                   XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0]      TRAP_VECTOR  = 32'h0000_0004,
    parameter int                   INC          = 4,
    parameter int                   ALIGN_BITS   = 2,
    parameter int                   HOLD_CYCLES  = 1
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic [XLEN-1:0] pc_next_seq_o,
    output logic            misalign_o,
    output logic [XLEN-1:0] misalign_addr_o
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
    localparam logic [XLEN-1:0]  INC_V     = XLEN'(INC);
    // A zero-width alignment field yields an all-zero mask, disabling the check.
    localparam logic [XLEN-1:0]  ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);

    typedef enum logic {
        ST_HOLD = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e RESET_STATE = (HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;

    function automatic logic is_misaligned(input logic [XLEN-1:0] target);
        return |(target & ALIGN_MASK);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              pend_trap_q, pend_trap_d;
    logic              pend_redir_q, pend_redir_d;
    logic [XLEN-1:0]   pend_target_q, pend_target_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   misalign_addr_q, misalign_addr_d;

    logic              redir_take;
    logic [XLEN-1:0]   redir_tgt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= RESET_STATE;
            hold_cnt_q      <= HOLD_INIT;
            pc_q            <= RESET_VECTOR;
            pend_trap_q     <= 1'b0;
            pend_redir_q    <= 1'b0;
            pend_target_q   <= '0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            pc_q            <= pc_d;
            pend_trap_q     <= pend_trap_d;
            pend_redir_q    <= pend_redir_d;
            pend_target_q   <= pend_target_d;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        pc_d            = pc_q;
        pend_trap_d     = pend_trap_q;
        pend_redir_d    = pend_redir_q;
        pend_target_d   = pend_target_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        redir_take      = 1'b0;
        redir_tgt       = '0;

        case (state_q)
            ST_HOLD: begin
                // Inputs are deliberately ignored until the hold window expires.
                pc_d = RESET_VECTOR;
                if (hold_cnt_q <= CNT_W'(1)) begin
                    hold_cnt_d = '0;
                    state_d    = ST_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (stall_i) begin
                    if (trap_i) begin
                        pend_trap_d = 1'b1;
                    end
                    if (redirect_valid_i) begin
                        pend_redir_d  = 1'b1;
                        pend_target_d = redirect_target_i;
                    end
                end else begin
                    pend_trap_d  = 1'b0;
                    pend_redir_d = 1'b0;
                    if (trap_i || pend_trap_q) begin
                        pc_d = TRAP_VECTOR;
                    end else if (redirect_valid_i) begin
                        redir_take = 1'b1;
                        redir_tgt  = redirect_target_i;
                    end else if (pend_redir_q) begin
                        redir_take = 1'b1;
                        redir_tgt  = pend_target_q;
                    end else begin
                        pc_d = pc_q + INC_V;
                    end

                    if (redir_take) begin
                        if (is_misaligned(redir_tgt)) begin
                            pc_d            = TRAP_VECTOR;
                            misalign_d      = 1'b1;
                            misalign_addr_d = redir_tgt;
                        end else begin
                            pc_d = redir_tgt;
                        end
                    end
                end
            end

            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    assign pc_o            = pc_q;
    assign pc_valid_o      = (state_q == ST_RUN);
    assign pc_next_seq_o   = pc_q + INC_V;
    assign misalign_o      = misalign_q;
    assign misalign_addr_o = misalign_addr_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: one instance with default parameters and one with a
// three-cycle reset hold, both driven by the same stimulus.
module tb_pc_gen;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redir_vld;
    logic [31:0] redir_tgt;
    logic        trap;

    logic [31:0] pc_a, seq_a, maddr_a;
    logic        vld_a, mis_a;
    logic [31:0] pc_b, seq_b, maddr_b;
    logic        vld_b, mis_b;

    int n_total = 0;
    int n_bad   = 0;

    pc_gen u_dut (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .stall_i           (stall),
        .redirect_valid_i  (redir_vld),
        .redirect_target_i (redir_tgt),
        .trap_i            (trap),
        .pc_o              (pc_a),
        .pc_valid_o        (vld_a),
        .pc_next_seq_o     (seq_a),
        .misalign_o        (mis_a),
        .misalign_addr_o   (maddr_a)
    );

    pc_gen #(.HOLD_CYCLES(3)) u_dut_h3 (
        .clk_i             (clk),
        .rst_n_i           (rst_n),
        .stall_i           (stall),
        .redirect_valid_i  (redir_vld),
        .redirect_target_i (redir_tgt),
        .trap_i            (trap),
        .pc_o              (pc_b),
        .pc_valid_o        (vld_b),
        .pc_next_seq_o     (seq_b),
        .misalign_o        (mis_b),
        .misalign_addr_o   (maddr_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic rv, input logic [31:0] rt, input logic t);
        stall     = s;
        redir_vld = rv;
        redir_tgt = rt;
        trap      = t;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0);
        tick();
        tick();
        chk("rst_pc",      pc_a,    32'h0);
        chk("rst_valid",   {31'b0, vld_a}, 32'h0);
        chk("rst_mis",     {31'b0, mis_a}, 32'h0);
        chk("rst_maddr",   maddr_a, 32'h0);
        chk("rst_seq",     seq_a,   32'h4);
        chk("rst_h3_vld",  {31'b0, vld_b}, 32'h0);

        // Reset release: A holds one edge, B three edges.
        rst_n = 1'b1;
        tick();
        chk("e1_pc",     pc_a, 32'h0);
        chk("e1_valid",  {31'b0, vld_a}, 32'h1);
        chk("e1_h3_vld", {31'b0, vld_b}, 32'h0);
        tick();
        chk("e2_pc",     pc_a, 32'h4);
        chk("e2_h3_pc",  pc_b, 32'h0);
        tick();
        chk("e3_pc",     pc_a, 32'h8);
        chk("e3_seq",    seq_a, 32'hC);
        chk("e3_h3_vld", {31'b0, vld_b}, 32'h1);
        chk("e3_h3_pc",  pc_b, 32'h0);

        // Plain redirect with one-cycle latency.
        drive(0, 1, 32'h100, 0);
        tick();
        chk("jmp100_pc", pc_a, 32'h100);
        chk("jmp100_h3", pc_b, 32'h100);
        drive(0, 1, 32'h200, 0);
        tick();
        chk("jmp200_pc", pc_a, 32'h200);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("seq204_pc",  pc_a, 32'h204);
        chk("seq204_nxt", seq_a, 32'h208);

        // Stall: later buffered redirect overwrites the earlier one.
        drive(0, 1, 32'h40, 0);
        tick();
        chk("to40_pc", pc_a, 32'h40);
        drive(1, 1, 32'h80, 0);
        tick();
        chk("stall1_pc", pc_a, 32'h40);
        drive(1, 1, 32'h90, 0);
        tick();
        chk("stall2_pc", pc_a, 32'h40);
        drive(1, 0, 32'h0, 0);
        tick();
        chk("stall3_pc", pc_a, 32'h40);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("rel_pc90", pc_a, 32'h90);
        tick();
        chk("rel_pc94", pc_a, 32'h94);

        // Buffered trap beats a later buffered redirect; buffer is empty afterwards.
        drive(1, 0, 32'h0, 1);
        tick();
        drive(1, 1, 32'h300, 0);
        tick();
        drive(1, 0, 32'h0, 0);
        tick();
        chk("trapst_pc", pc_a, 32'h94);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("trapbuf_pc", pc_a, 32'h4);
        tick();
        chk("trapclr_pc", pc_a, 32'h8);
        chk("trapclr_mis", {31'b0, mis_a}, 32'h0);

        // A trap on the release edge beats a buffered redirect.
        drive(1, 1, 32'h500, 0);
        tick();
        drive(0, 0, 32'h0, 1);
        tick();
        chk("reltrap_pc", pc_a, 32'h4);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("reltrap_nx", pc_a, 32'h8);

        // Live trap beats a live redirect.
        drive(0, 1, 32'h700, 1);
        tick();
        chk("trapvsjmp", pc_a, 32'h4);

        // Misaligned live redirect.
        drive(0, 1, 32'h202, 0);
        tick();
        chk("mis_pc",    pc_a, 32'h4);
        chk("mis_pulse", {31'b0, mis_a}, 32'h1);
        chk("mis_addr",  maddr_a, 32'h202);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("mis_pc2",   pc_a, 32'h8);
        chk("mis_drop",  {31'b0, mis_a}, 32'h0);
        chk("mis_keep",  maddr_a, 32'h202);

        // Misaligned buffered redirect.
        drive(1, 1, 32'h301, 0);
        tick();
        chk("mis_st_pulse", {31'b0, mis_a}, 32'h0);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("misbuf_pc",   pc_a, 32'h4);
        chk("misbuf_mis",  {31'b0, mis_a}, 32'h1);
        chk("misbuf_addr", maddr_a, 32'h301);

        // Sequential wrap at the top of the address space.
        drive(0, 1, 32'hFFFF_FFFC, 0);
        tick();
        chk("wrap_pc",  pc_a, 32'hFFFF_FFFC);
        chk("wrap_seq", seq_a, 32'h0);
        drive(0, 0, 32'h0, 0);
        tick();
        chk("wrap_pc0", pc_a, 32'h0);

        // Asynchronous reset mid-RUN discards a buffered redirect.
        drive(1, 1, 32'h600, 0);
        tick();
        drive(0, 0, 32'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    pc_a, 32'h0);
        chk("arst_vld",   {31'b0, vld_a}, 32'h0);
        chk("arst_maddr", maddr_a, 32'h0);
        chk("arst_h3_pc", pc_b, 32'h0);
        chk("arst_h3_v",  {31'b0, vld_b}, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("r1_vld",   {31'b0, vld_a}, 32'h1);
        chk("r1_h3_v",  {31'b0, vld_b}, 32'h0);
        tick();
        chk("r2_pc",    pc_a, 32'h4);
        chk("r2_h3_v",  {31'b0, vld_b}, 32'h0);
        tick();
        chk("r3_h3_v",  {31'b0, vld_b}, 32'h1);
        chk("r3_h3_pc", pc_b, 32'h0);
        tick();
        chk("r4_h3_pc", pc_b, 32'h4);
        chk("r4_pc",    pc_a, 32'hC);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
